// File: rtl/obb_pkg.sv
// Shared definitions for the OBB corner reader.
//   W          signed corner coordinate width
//   NC         corners per box (fixed at 8)
//   AXES       axes per corner (x, y, z)
//   CW / BW    packed width of one corner / one full box
//   obb_state_e  reader FSM encoding (IDLE, SCAN, CMP)
//   corner_lsb   bit offset of corner k, axis a inside a packed box
package obb_pkg;

  localparam int W    = 17;
  localparam int NC   = 8;
  localparam int AXES = 3;
  localparam int CW   = AXES * W;
  localparam int BW   = NC * CW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CMP  = 2'd2
  } obb_state_e;

  // Corner k, axis a lives at bits [(3k+a)*W +: W] of a packed box.
  function automatic int unsigned corner_lsb(input int unsigned k, input int unsigned a);
    return (AXES * k + a) * W;
  endfunction

endpackage

// File: rtl/obb_minmax_acc.sv
// Three-axis signed min/max accumulator.
//   clk, rst   clock, asynchronous active-low reset (bounds clear to 0)
//   load       seed min and max from c (first corner of a box)
//   update     fold c into the running bounds (load wins if both high)
//   c          one corner, axis a at [a*W +: W]
//   min_v      running per-axis minimum, same packing as c
//   max_v      running per-axis maximum, same packing as c
module obb_minmax_acc
  import obb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          update,
  input  logic [CW-1:0] c,
  output logic [CW-1:0] min_v,
  output logic [CW-1:0] max_v
);

  for (genvar a = 0; a < AXES; a++) begin : g_axis
    logic signed [W-1:0] cv;
    logic signed [W-1:0] mn_q;
    logic signed [W-1:0] mx_q;

    assign cv = $signed(c[a*W +: W]);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mn_q <= '0;
        mx_q <= '0;
      end else if (load) begin
        mn_q <= cv;
        mx_q <= cv;
      end else if (update) begin
        mn_q <= (cv < mn_q) ? cv : mn_q;
        mx_q <= (cv > mx_q) ? cv : mx_q;
      end
    end

    assign min_v[a*W +: W] = mn_q;
    assign max_v[a*W +: W] = mx_q;
  end

endmodule

// File: rtl/obb_collide_reader.sv
// Consumer end of the OBB corner interface. Captures two 8-corner boxes,
// scans all 16 corners serially into per-axis bounds, then issues a
// one-cycle axis-aligned overlap verdict.
//   clk, rst     clock, asynchronous active-low reset
//   in_valid     corner set on in_corners is valid
//   in_ready     block can accept a corner set (IDLE only)
//   in_box       0 = load box A, 1 = load box B
//   in_corners   packed corner set, corner k axis a at [(3k+a)*W +: W]
//   busy         high in SCAN or CMP
//   done         one-cycle pulse, collide/ovl valid
//   collide      overlap on all three axes
//   ovl          per-axis overlap flags {z,y,x}
//   dbg_state    current FSM state (obb_state_e encoding)
//
// Handshake: a corner set transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on state (never on in_valid)
// and in_corners is sampled only on that transfer edge.
module obb_collide_reader
  import obb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_box,
  input  logic [BW-1:0] in_corners,
  output logic          busy,
  output logic          done,
  output logic          collide,
  output logic [2:0]    ovl,
  output logic [1:0]    dbg_state
);

  obb_state_e    state;
  logic          have_a;
  logic          have_b;
  logic [BW-1:0] box_a;
  logic [BW-1:0] box_b;
  logic [3:0]    idx;
  logic          accept;
  logic [2:0]    k;
  logic [CW-1:0] corner;
  logic [CW-1:0] a_min, a_max, b_min, b_max;
  logic [2:0]    ovl_next;
  logic          scan;

  // in_ready is held low while reset is asserted, then follows IDLE.
  assign in_ready  = rst && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign scan      = (state == ST_SCAN);

  // idx[3] selects the box, idx[2:0] the corner within it.
  assign k = idx[2:0];

  always_comb begin
    corner = box_a[corner_lsb(32'(k), 0) +: CW];
    if (idx[3]) corner = box_b[corner_lsb(32'(k), 0) +: CW];
  end

  obb_minmax_acc u_acc_a (
    .clk    (clk),
    .rst    (rst),
    .load   (scan && (idx == 4'd0)),
    .update (scan && !idx[3]),
    .c      (corner),
    .min_v  (a_min),
    .max_v  (a_max)
  );

  obb_minmax_acc u_acc_b (
    .clk    (clk),
    .rst    (rst),
    .load   (scan && (idx == 4'd8)),
    .update (scan && idx[3]),
    .c      (corner),
    .min_v  (b_min),
    .max_v  (b_max)
  );

  // Touching faces (equal bounds) count as overlap.
  always_comb begin
    ovl_next = '0;
    for (int a = 0; a < AXES; a++) begin
      ovl_next[a] = ($signed(a_min[a*W +: W]) <= $signed(b_max[a*W +: W])) &&
                    ($signed(b_min[a*W +: W]) <= $signed(a_max[a*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      have_a  <= 1'b0;
      have_b  <= 1'b0;
      box_a   <= '0;
      box_b   <= '0;
      idx     <= '0;
      done    <= 1'b0;
      collide <= 1'b0;
      ovl     <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (in_box) box_b <= in_corners;
            else        box_a <= in_corners;
            have_a <= have_a | ~in_box;
            have_b <= have_b | in_box;
            // The accept itself may complete the pair.
            if ((have_a || !in_box) && (have_b || in_box)) begin
              state <= ST_SCAN;
              idx   <= '0;
            end
          end
        end
        ST_SCAN: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= ST_CMP;
        end
        ST_CMP: begin
          ovl     <= ovl_next;
          collide <= &ovl_next;
          done    <= 1'b1;
          have_a  <= 1'b0;
          have_b  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obb_collide_reader.sv
// Self-checking bench for obb_collide_reader: drives box pairs, predicts
// verdict and done cycle from its own bounds model, and compares on done.
module tb_obb_collide_reader;
  import obb_pkg::*;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_box = 1'b0;
  logic [BW-1:0] in_corners = '0;
  logic          in_ready, busy, done, collide;
  logic [2:0]    ovl;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obb_collide_reader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_box     (in_box),
    .in_corners (in_corners),
    .busy       (busy),
    .done       (done),
    .collide    (collide),
    .ovl        (ovl),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [3:0]    exp_q[$];
  int unsigned   due_q[$];
  logic [BW-1:0] cur_a, cur_b;
  bit            m_have_a = 0, m_have_b = 0;
  logic [3:0]    last_res = 4'b0;
  logic [3:0]    mon_e;
  int unsigned   mon_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] make_box(input int xl, input int xh, input int yl,
                                             input int yh, input int zl, input int zh);
    logic [BW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      v[(3*c+0)*W +: W] = W'((c & 1) != 0 ? xh : xl);
      v[(3*c+1)*W +: W] = W'((c & 2) != 0 ? yh : yl);
      v[(3*c+2)*W +: W] = W'((c & 4) != 0 ? zh : zl);
    end
    return v;
  endfunction

  // Returns {collide, ovl[2:0]} from bounds gathered over all corners.
  function automatic logic [3:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [3:0] r;
    int amin, amax, bmin, bmax, va, vb;
    r = '0;
    for (int ax = 0; ax < 3; ax++) begin
      amin = 1 << 20; amax = -(1 << 20);
      bmin = 1 << 20; bmax = -(1 << 20);
      for (int c = 0; c < NC; c++) begin
        va = int'($signed(a[(3*c+ax)*W +: W]));
        vb = int'($signed(b[(3*c+ax)*W +: W]));
        if (va < amin) amin = va;
        if (va > amax) amax = va;
        if (vb < bmin) bmin = vb;
        if (vb > bmax) bmax = vb;
      end
      r[ax] = (amin <= bmax) && (bmin <= amax);
    end
    r[3] = &r[2:0];
    return r;
  endfunction

  // monitor: pop an expectation on every done pulse
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        check("collide", 32'(collide), 32'(mon_e[3]));
        check("ovl", 32'(ovl), 32'(mon_e[2:0]));
        check("done_cycle", cyc, mon_d);
      end
    end
  end

  // driver tasks
  task automatic send(input bit box, input logic [BW-1:0] v);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid   = 1'b1;
    in_box     = box;
    in_corners = v;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_corners = ~v;  // later changes must be ignored
    if (box) begin cur_b = v; m_have_b = 1; end
    else     begin cur_a = v; m_have_a = 1; end
    if (m_have_a && m_have_b) begin
      last_res = model(cur_a, cur_b);
      exp_q.push_back(last_res);
      due_q.push_back(cyc + 17);
      m_have_a = 0;
      m_have_b = 0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      due_q.delete();
    end
    repeat (3) @(negedge clk);
    check("collide_hold", 32'(collide), 32'(last_res[3]));
    check("ovl_hold", 32'(ovl), 32'(last_res[2:0]));
  endtask

  task automatic pair(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit b_first);
    if (b_first) begin send(1, b); send(0, a); end
    else         begin send(0, a); send(1, b); end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [BW-1:0] box_p, box_q;
  int lo, sz, lo2, sz2;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_collide", 32'(collide), 32'd0);
    check("rst_ovl", 32'(ovl), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(5, 15, 5, 15, 5, 15), 0);
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(11, 20, 0, 10, 0, 10), 0);
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(10, 20, 0, 10, 0, 10), 0);
    pair(make_box(-65536, -1, -65536, -1, -65536, -1),
         make_box(0, 65535, 0, 65535, 0, 65535), 0);
    pair(make_box(-65536, -1, -65536, -1, -65536, -1),
         make_box(-1, 65535, -1, 65535, -1, 65535), 0);
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(5, 15, 5, 15, 5, 15), 1);
    pair(make_box(0, 10, 20, 30, 0, 10), make_box(5, 15, 5, 15, 5, 15), 1);

    // overwrite: far A replaced by overlapping A
    send(0, make_box(100, 110, 100, 110, 100, 110));
    send(0, make_box(0, 10, 0, 10, 0, 10));
    send(1, make_box(5, 15, 5, 15, 5, 15));
    wait_idle();

    // in_valid held during SCAN must not be captured
    send(0, make_box(0, 10, 0, 10, 0, 10));
    send(1, make_box(5, 15, 5, 15, 5, 15));
    in_valid   = 1'b1;
    in_box     = 1'b0;
    in_corners = make_box(200, 210, 200, 210, 200, 210);
    repeat (10) begin
      @(negedge clk);
      check("ready_in_scan", 32'(in_ready), 32'd0);
      check("busy_in_scan", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    wait_idle();

    // reset mid-SCAN at idx=7
    send(0, make_box(0, 10, 0, 10, 0, 10));
    send(1, make_box(5, 15, 5, 15, 5, 15));
    repeat (7) @(posedge clk);
    #1;
    check("scan_state", 32'(dbg_state), 32'(ST_SCAN));
    rst = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    last_res = 4'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_collide", 32'(collide), 32'd0);
    check("midrst_ovl", 32'(ovl), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    repeat (25) @(negedge clk);
    check("midrst_no_done_collide", 32'(collide), 32'd0);
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(11, 20, 0, 10, 0, 10), 0);
    pair(make_box(0, 10, 0, 10, 0, 10), make_box(5, 15, 5, 15, 5, 15), 0);

    // randomised boxes, signed ranges, random load order
    for (int n = 0; n < 8; n++) begin
      lo = $urandom_range(0, 80) - 40; sz = $urandom_range(0, 30);
      lo2 = $urandom_range(0, 80) - 40; sz2 = $urandom_range(0, 30);
      box_p = make_box(lo, lo + sz, lo2, lo2 + sz2, lo, lo + sz2);
      lo = $urandom_range(0, 80) - 40; sz = $urandom_range(0, 30);
      lo2 = $urandom_range(0, 80) - 40; sz2 = $urandom_range(0, 30);
      box_q = make_box(lo, lo + sz, lo2, lo2 + sz, lo2, lo2 + sz2);
      pair(box_p, box_q, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
